// File: rtl/pc_sequenciador.sv
// ---------------------------------------------------------------------------
// pc_sequenciador : IF-stage program counter with prioritised next-PC,
//                   circular return-address stack, previous-PC and EPC.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequenciador #(
   parameter int                 LARGURA   = 32,
   parameter logic [LARGURA-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [LARGURA-1:0] EXC_VEC   = 32'h8000_0180,
   parameter int                 PASSO     = 4,
   parameter int                 PROF_RAS  = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               pc_escreve,
   input  logic               desvio,
   input  logic [LARGURA-1:0] alvo_desvio,
   input  logic               salto,
   input  logic [LARGURA-1:0] alvo_salto,
   input  logic               chamada,
   input  logic               retorno,
   input  logic               excecao,
   output logic [LARGURA-1:0] pc_saida,
   output logic [LARGURA-1:0] pc_mais_passo,
   output logic [LARGURA-1:0] pc_anterior,
   output logic [LARGURA-1:0] epc,
   output logic               ras_vazia,
   output logic               ras_cheia
);

   localparam int                 c_PW      = $clog2(PROF_RAS);
   localparam int                 c_CW      = $clog2(PROF_RAS + 1);
   localparam logic [c_PW-1:0]    c_PTR_MAX = c_PW'(PROF_RAS - 1);
   localparam logic [c_CW-1:0]    c_CNT_MAX = c_CW'(PROF_RAS);
   localparam logic [LARGURA-1:0] c_PASSO   = LARGURA'(PASSO);

   logic [LARGURA-1:0] pc_q, pc_d;
   logic [LARGURA-1:0] pc_ant_q, pc_ant_d;
   logic [LARGURA-1:0] epc_q, epc_d;
   logic [c_PW-1:0]    ptr_q, ptr_d;
   logic [c_CW-1:0]    cnt_q, cnt_d;
   logic [LARGURA-1:0] ras_q [PROF_RAS];
   logic [LARGURA-1:0] ras_d [PROF_RAS];

   logic [LARGURA-1:0] w_ret;
   logic [LARGURA-1:0] w_topo;
   logic [c_PW-1:0]    w_ptr_inc;
   logic [c_PW-1:0]    w_ptr_dec;
   logic               w_vazia;

   // ptr_q names the next free slot; the top of stack sits one below it.
   assign w_ret     = pc_q + c_PASSO;
   assign w_ptr_inc = (ptr_q == c_PTR_MAX) ? '0 : ptr_q + c_PW'(1);
   assign w_ptr_dec = (ptr_q == '0) ? c_PTR_MAX : ptr_q - c_PW'(1);
   assign w_topo    = ras_q[w_ptr_dec];
   assign w_vazia   = (cnt_q == '0);

   always_comb begin
      pc_d     = pc_q;
      pc_ant_d = pc_ant_q;
      epc_d    = epc_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      ras_d    = ras_q;

      if (excecao) begin
         pc_d     = EXC_VEC;
         pc_ant_d = pc_q;
         epc_d    = pc_q;
      end else if (pc_escreve) begin
         pc_ant_d = pc_q;
         if (desvio)
            pc_d = alvo_desvio;
         else if (retorno)
            pc_d = w_vazia ? alvo_salto : w_topo;
         else if (salto)
            pc_d = alvo_salto;
         else
            pc_d = w_ret;

         // A taken branch squashes the call/return in the same slot.
         if (!desvio) begin
            if (chamada && retorno && !w_vazia) begin
               ras_d[w_ptr_dec] = w_ret;
            end else if (chamada) begin
               ras_d[ptr_q] = w_ret;
               ptr_d        = w_ptr_inc;
               if (cnt_q != c_CNT_MAX)
                  cnt_d = cnt_q + c_CW'(1);
            end else if (retorno && !w_vazia) begin
               ptr_d = w_ptr_dec;
               cnt_d = cnt_q - c_CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q     <= RESET_VEC;
         pc_ant_q <= RESET_VEC;
         epc_q    <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         pc_ant_q <= pc_ant_d;
         epc_q    <= epc_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Stack contents carry no reset; validity is tracked by cnt_q alone.
   always_ff @(posedge clock) begin
      ras_q <= ras_d;
   end

   assign pc_saida      = pc_q;
   assign pc_mais_passo = w_ret;
   assign pc_anterior   = pc_ant_q;
   assign epc           = epc_q;
   assign ras_vazia     = w_vazia;
   assign ras_cheia     = (cnt_q == c_CNT_MAX);

endmodule

`default_nettype wire
